// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock/reset wrapper blocks.
// Holds the sequencer state encoding and a counter-width helper.
package clk_rst_pkg;

  localparam int SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    RESET       = 2'd0,
    WAIT_STABLE = 2'd1,
    RELEASE     = 2'd2,
    RUN         = 2'd3
  } seq_state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level into in_clk.
// Shared by every block that must sample a foreign-domain flag.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic in_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge in_clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered per-domain reset release gated on a stable, synchronised PLL lock.
// Any lock loss after release re-asserts everything and is counted.
module reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int N_CH               = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int CNT_W              = 8
) (
  input  logic                   in_clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic [N_CH-1:0]        chan_hold,
  output logic [N_CH-1:0]        ch_rst,
  output logic                   all_ready,
  output logic [CNT_W-1:0]       lock_loss_cnt,
  output logic [SEQ_STATE_W-1:0] seq_state
);

  localparam int STAB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int GAP_W  = cnt_width(STAGE_GAP_CYCLES);
  localparam int IDX_W  = cnt_width(N_CH + 1);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH);

  logic lock_s;

  seq_state_t        state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_CH-1:0]   seq_rst_q, seq_rst_d;
  logic [CNT_W-1:0]  loss_q, loss_d;
  logic [N_CH-1:0]   ch_rst_q;
  logic              all_ready_q;
  logic              gap_wrap;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .in_clk (in_clk),
    .rst    (rst),
    .d      (pll_locked),
    .q      (lock_s)
  );

  assign gap_wrap = (gap_q == GAP_LAST);

  always_comb begin
    state_d   = state_q;
    seq_rst_d = seq_rst_q;
    loss_d    = loss_q;
    case (state_q)
      RESET: begin
        seq_rst_d = '1;
        if (lock_s) state_d = WAIT_STABLE;
      end
      WAIT_STABLE: begin
        if (!lock_s) begin
          state_d   = RESET;
          seq_rst_d = '1;
        end else if (stab_q == STAB_LAST) begin
          state_d      = RELEASE;
          seq_rst_d[0] = 1'b0;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d   = RESET;
          seq_rst_d = '1;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end else if (gap_wrap) begin
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
          end else begin
            for (int i = 0; i < N_CH; i++) begin
              if (idx_q == IDX_W'(i)) seq_rst_d[i] = 1'b0;
            end
          end
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = RESET;
          seq_rst_d = '1;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = RESET;
        seq_rst_d = '1;
      end
    endcase
  end

  // Counters only advance while their state persists, so none can wrap before its compare.
  always_comb begin
    stab_d = '0;
    if (state_q == WAIT_STABLE && state_d == WAIT_STABLE) stab_d = stab_q + STAB_W'(1);
  end

  always_comb begin
    gap_d = '0;
    if (state_q == RELEASE && state_d == RELEASE) gap_d = gap_wrap ? '0 : gap_q + GAP_W'(1);
  end

  always_comb begin
    idx_d = idx_q;
    if (state_q == WAIT_STABLE && state_d == RELEASE) begin
      idx_d = IDX_W'(1);
    end else if (state_q == RELEASE && state_d == RELEASE && gap_wrap) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q     <= RESET;
      stab_q      <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      seq_rst_q   <= '1;
      loss_q      <= '0;
      ch_rst_q    <= '1;
      all_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_q      <= stab_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      seq_rst_q   <= seq_rst_d;
      loss_q      <= loss_d;
      ch_rst_q    <= seq_rst_d | chan_hold;
      all_ready_q <= (state_d == RUN);
    end
  end

  assign ch_rst        = ch_rst_q;
  assign all_ready     = all_ready_q;
  assign lock_loss_cnt = loss_q;
  assign seq_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timeline cases plus random lock/hold traffic.
// Expected outputs come from a timeline model: time since the sequence started decides each release.
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int LSC  = 8;
  localparam int GAP  = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TRUN = LSC + N * GAP;

  logic          in_clk;
  logic          rst;
  logic          pll_locked;
  logic [N-1:0]  chan_hold;
  logic [N-1:0]  ch_rst;
  logic          all_ready;
  logic [CW-1:0] lock_loss_cnt;
  logic [1:0]    seq_state;

  int nChecks = 0;
  int nFails  = 0;

  logic   lockHist[$];
  bit     mActive;
  bit     mRst;
  int     mT;
  int     mCnt;
  logic [N-1:0] mHold;

  int edgeIdx;
  int fallAt[N];
  int readyAt;

  reset_sequencer #(
    .N_CH               (N),
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (LSC),
    .STAGE_GAP_CYCLES   (GAP),
    .CNT_W              (CW)
  ) dut (
    .in_clk        (in_clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .chan_hold     (chan_hold),
    .ch_rst        (ch_rst),
    .all_ready     (all_ready),
    .lock_loss_cnt (lock_loss_cnt),
    .seq_state     (seq_state)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model advances on each edge: a sequence starts when synced lock is first seen,
  // channel k is released LSC + k*GAP edges later, RUN after the last gap.
  task automatic modelEdge();
    logic ls;
    if (rst) begin
      mActive = 0;
      mT      = 0;
      mCnt    = 0;
      mRst    = 1;
      lockHist.delete();
      repeat (SYNC) lockHist.push_back(1'b0);
    end else begin
      mRst = 0;
      ls = lockHist.pop_front();
      lockHist.push_back(pll_locked);
      if (!mActive) begin
        if (ls) begin
          mActive = 1;
          mT      = 0;
        end
      end else if (!ls) begin
        if (mT >= LSC) mCnt = (mCnt == CMAX) ? CMAX : mCnt + 1;
        mActive = 0;
      end else if (mT < TRUN) begin
        mT++;
      end
    end
    mHold = chan_hold;
  endtask

  task automatic compareModel();
    logic [N-1:0] expCh;
    logic [1:0]   expState;
    logic         expReady;
    for (int k = 0; k < N; k++) begin
      expCh[k] = mRst ? 1'b1 : (!(mActive && mT >= LSC + k * GAP) || mHold[k]);
    end
    expReady = mActive && (mT >= TRUN);
    if (!mActive)        expState = 2'd0;
    else if (mT < LSC)   expState = 2'd1;
    else if (mT < TRUN)  expState = 2'd2;
    else                 expState = 2'd3;
    checkOutput("ch_rst", 32'(ch_rst), 32'(expCh));
    checkOutput("all_ready", 32'(all_ready), 32'(expReady));
    checkOutput("seq_state", 32'(seq_state), 32'(expState));
    checkOutput("lock_loss_cnt", 32'(lock_loss_cnt), 32'(mCnt));
  endtask

  task automatic clearTimeline();
    edgeIdx = 0;
    readyAt = -1;
    for (int k = 0; k < N; k++) fallAt[k] = -1;
  endtask

  task automatic applyStimulus(input logic lockIn, input logic [N-1:0] holdIn,
                               input logic rstIn, input int cycles);
    pll_locked = lockIn;
    chan_hold  = holdIn;
    rst        = rstIn;
    for (int c = 0; c < cycles; c++) begin
      @(posedge in_clk);
      modelEdge();
      #1;
      compareModel();
      for (int k = 0; k < N; k++) begin
        if (fallAt[k] < 0 && ch_rst[k] === 1'b0) fallAt[k] = edgeIdx;
      end
      if (readyAt < 0 && all_ready === 1'b1) readyAt = edgeIdx;
      edgeIdx++;
    end
  endtask

  initial begin
    logic         lockR;
    logic         rstR;
    logic [N-1:0] holdR;

    lockHist.delete();
    repeat (SYNC) lockHist.push_back(1'b0);
    mActive = 0; mRst = 1; mT = 0; mCnt = 0; mHold = '0;
    clearTimeline();

    // Reset values, then normal release from cycle 0.
    applyStimulus(1'b0, '0, 1'b1, 3);
    checkOutput("reset ch_rst", 32'(ch_rst), 32'hF);
    checkOutput("reset seq_state", 32'(seq_state), 32'd0);
    clearTimeline();
    applyStimulus(1'b1, '0, 1'b0, 30);
    for (int k = 0; k < N; k++) checkOutput($sformatf("case1 fall%0d", k), 32'(fallAt[k]), 32'(10 + 4 * k));
    checkOutput("case1 ready", 32'(readyAt), 32'd26);

    // Unstable lock: one-cycle dip restarts the stability window.
    applyStimulus(1'b0, '0, 1'b1, 2);
    clearTimeline();
    applyStimulus(1'b1, '0, 1'b0, 5);
    applyStimulus(1'b0, '0, 1'b0, 1);
    applyStimulus(1'b1, '0, 1'b0, 30);
    checkOutput("case2 fall0", 32'(fallAt[0]), 32'd16);
    checkOutput("case2 ready", 32'(readyAt), 32'd32);
    checkOutput("case2 cnt", 32'(lock_loss_cnt), 32'd0);

    // Lock loss in RUN, then replay.
    applyStimulus(1'b0, '0, 1'b0, 3);
    checkOutput("case3 ch_rst", 32'(ch_rst), 32'hF);
    checkOutput("case3 ready", 32'(all_ready), 32'd0);
    checkOutput("case3 cnt", 32'(lock_loss_cnt), 32'd1);
    clearTimeline();
    applyStimulus(1'b1, '0, 1'b0, 30);
    checkOutput("case3 refall0", 32'(fallAt[0]), 32'd10);
    checkOutput("case3 reready", 32'(readyAt), 32'd26);

    // Lock loss just after channel 1 releases.
    applyStimulus(1'b0, '0, 1'b1, 2);
    clearTimeline();
    applyStimulus(1'b1, '0, 1'b0, 15);
    applyStimulus(1'b0, '0, 1'b0, 6);
    checkOutput("case4 fall1", 32'(fallAt[1]), 32'd14);
    checkOutput("case4 fall2", 32'(fallAt[2]), 32'hFFFF_FFFF);
    checkOutput("case4 fall3", 32'(fallAt[3]), 32'hFFFF_FFFF);
    checkOutput("case4 ch_rst", 32'(ch_rst), 32'hF);
    checkOutput("case4 cnt", 32'(lock_loss_cnt), 32'd1);

    // Software hold on channel 2.
    applyStimulus(1'b0, '0, 1'b1, 2);
    clearTimeline();
    applyStimulus(1'b1, 4'b0100, 1'b0, 30);
    checkOutput("case5 fall0", 32'(fallAt[0]), 32'd10);
    checkOutput("case5 fall1", 32'(fallAt[1]), 32'd14);
    checkOutput("case5 fall2", 32'(fallAt[2]), 32'hFFFF_FFFF);
    checkOutput("case5 fall3", 32'(fallAt[3]), 32'd22);
    checkOutput("case5 ready", 32'(readyAt), 32'd26);
    applyStimulus(1'b1, '0, 1'b0, 1);
    checkOutput("case5 unhold", 32'(ch_rst), 32'h0);

    // Random lock, hold and reset traffic.
    for (int s = 0; s < 80; s++) begin
      lockR = ($urandom_range(3, 0) != 0);
      holdR = ($urandom_range(3, 0) == 0) ? N'($urandom) : '0;
      rstR  = ($urandom_range(19, 0) == 0);
      applyStimulus(lockR, holdR, rstR, rstR ? 1 : int'($urandom_range(20, 1)));
    end

    // Saturate the loss counter, then reset mid-RELEASE with a coincident lock drop.
    applyStimulus(1'b0, '0, 1'b1, 2);
    for (int e = 0; e < 300; e++) begin
      applyStimulus(1'b1, '0, 1'b0, 12);
      applyStimulus(1'b0, '0, 1'b0, 3);
    end
    checkOutput("case6 saturated", 32'(lock_loss_cnt), 32'd255);
    applyStimulus(1'b1, '0, 1'b0, 12);
    applyStimulus(1'b0, '0, 1'b0, 2);
    checkOutput("case6 in release", 32'(seq_state), 32'd2);
    applyStimulus(1'b0, '0, 1'b1, 1);
    checkOutput("case6 cnt", 32'(lock_loss_cnt), 32'd0);
    checkOutput("case6 ch_rst", 32'(ch_rst), 32'hF);
    checkOutput("case6 ready", 32'(all_ready), 32'd0);
    checkOutput("case6 state", 32'(seq_state), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
